fft_twiddle_multiplier: RTL and testbench
=========================================

// Module: fft_twiddle_multiplier
// PURPOSE
//  - Pipelined 16-lane complex multiplier between the twiddle-factor ROMs and the DIT butterfly add/sub stage.
//  - Drives the ROM stage address (0..4) from an internal stage counter and samples the returned real/imag twiddle vectors.
//  - Returns the rounded products (odd-half operand x W) to the butterfly add/sub over a valid/ready handshake.
//  - Twiddles and operands are signed Q(WIDTH-FRAC).FRAC; 256 = 1.0 at defaults.
// PARAMETERS
//  WIDTH  16  signed lane width of operands, twiddles and results
//  FRAC    8  fractional bits of twiddles; product scaled by 2^-FRAC
// PORTS
//  CLK        in   1          clock, rising edge
//  RST        in   1          async active-low reset
//  start      in   1          frame start: stage counter forced to 0
//  tw_address out  3          ROM stage address = stage counter
//  tw_re      in   WIDTH*16   real twiddles from ROM; lane k = bits [k*WIDTH +: WIDTH]
//  tw_im      in   WIDTH*16   imag twiddles from ROM; same lane packing
//  in_valid   in   1          operand vector valid
//  in_ready   out  1          block can accept operand vector
//  in_re      in   WIDTH*16   operand real, 16 lanes
//  in_im      in   WIDTH*16   operand imag, 16 lanes
//  out_valid  out  1          product vector valid
//  out_ready  in   1          downstream accepts product
//  out_re     out  WIDTH*16   product real, 16 lanes
//  out_im     out  WIDTH*16   product imag, 16 lanes
//  out_stage  out  3          stage tag of the product vector
//  ovf        out  1          sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, RST=0): stage_q=0, s1_valid=0, out_valid=0, out_re/out_im=0, out_stage=0, ovf=0; in-flight vectors discarded.
//  - tw_address = stage_q, combinational; ROM is combinational, so tw_re/tw_im are valid in the same cycle.
//  - Accept = in_valid & in_ready. On accept, S1 registers in_re, in_im, tw_re, tw_im and stage_q.
//  - Stage counter: on accept, stage_q wraps 4->0, else stage_q+1. start=1 forces stage_q=0 and takes priority over the increment.
//  - When start and accept coincide, the accepted vector is tagged with the pre-start stage_q.
//  - stage_q never takes values 5..7.
//  - Pipeline: S1 (operand/twiddle regs) -> S2 (multiply/round, output regs). Latency 2 cycles, accept to out_valid, with out_ready=1.
//  - Throughput: 1 vector/cycle.
//  - Flow control:
//    - s2_en = !out_valid | out_ready
//    - s1_en = !s1_valid | s2_en
//    - in_ready = s1_en
//  - Output registers hold stable while out_valid=1 and out_ready=0. No drop, no duplicate; order preserved.
//  - Per lane (ar,ai,wr,wi signed):
//    - pr = ar*wr - ai*wi; pi = ar*wi + ai*wr, at 2*WIDTH+1 bits.
//    - Round half-up: add 2^(FRAC-1), then arithmetic shift right FRAC.
//    - Narrow to WIDTH per CONFIGURATION.
//  - out_stage = S1 stage tag, passed along with the data.
// CONFIGURATION
//  FFT_TWID_SAT_EN defined:
//    - Lanes outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] clamp to the bound.
//    - ovf is set on any clamp of a vector transferred into S2.
//    - ovf stays set until reset.
//  FFT_TWID_SAT_EN undefined:
//    - Low WIDTH bits are kept (two's-complement wrap).
//    - ovf is tied to 0.
// TESTING
//  1 Identity: reset; tw_re lanes=256, tw_im=0, lane0 in=(100,-50) -> 2 cycles later out lane0=(100,-50), out_stage=0; tw_address=1 after accept.
//  2 W8 twiddle: tw=(181,-181), in=(256,0) -> out=(181,-181); in=(0,256) -> out=(181,181).
//  3 Rounding: in=(3,0), w=(128,0) -> out_re=2; in=(-3,0), same w -> out_re=-1.
//  4 Backpressure: out_ready=0 while sending 3 vectors -> 2 accepted, in_ready=0; output held stable; release -> drained in order with out_stage 0,1,2.
//  5 Overflow: in=(32767,32767), w=(256,256) -> out_re=0. out_im=32767 and ovf=1 with FFT_TWID_SAT_EN; out_im=-2 and ovf=0 without.
//  6 Wrap/start: 6 accepts -> tw_address 0,1,2,3,4,0; start with accept at stage 2 -> vector tagged 2, next tw_address=0; RST low mid-stream -> out_valid=0 at once.

Source files
------------

// File: rtl/fft_twiddle_multiplier.sv
// 16-lane pipelined complex multiplier (operand x twiddle) feeding the DIT butterfly add/sub stage.
// Define FFT_TWID_SAT_EN for saturating narrowing with a sticky ovf flag; otherwise results wrap.
module fft_twiddle_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  output logic [2:0]            tw_address,
  input  logic [WIDTH*16-1:0]   tw_re,
  input  logic [WIDTH*16-1:0]   tw_im,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*16-1:0]   in_re,
  input  logic [WIDTH*16-1:0]   in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*16-1:0]   out_re,
  output logic [WIDTH*16-1:0]   out_im,
  output logic [2:0]            out_stage,
  output logic                  ovf
);

  localparam int LANES = 16;
  localparam int VW    = WIDTH * LANES;
  localparam int PW    = 2 * WIDTH + 1;
  localparam logic [2:0]           LAST_STAGE = 3'd4;
  localparam logic signed [PW-1:0] RND_C = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
`ifdef FFT_TWID_SAT_EN
  localparam logic signed [PW-1:0] MAX_C = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_C = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  logic [2:0]           stage_r;
  logic                 s1_valid_r;
  logic [VW-1:0]        s1_re_r, s1_im_r, s1_tw_re_r, s1_tw_im_r;
  logic [2:0]           s1_stage_r;
  logic                 out_valid_r;
  logic [VW-1:0]        out_re_r, out_im_r;
  logic [2:0]           out_stage_r;
  logic                 s2_en_s, s1_en_s, accept_s;
  logic [VW-1:0]        prod_re_s, prod_im_s;
  logic signed [PW-1:0] rnd_re_s [LANES];
  logic signed [PW-1:0] rnd_im_s [LANES];
`ifdef FFT_TWID_SAT_EN
  logic                 clamp_s;
  logic                 ovf_r;
`endif

  function automatic logic signed [PW-1:0] cmul_re(input logic signed [WIDTH-1:0] ar, ai, wr, wi);
    logic signed [PW-1:0] xr, xi, yr, yi;
    xr = ar; xi = ai; yr = wr; yi = wi;
    return xr * yr - xi * yi;
  endfunction

  function automatic logic signed [PW-1:0] cmul_im(input logic signed [WIDTH-1:0] ar, ai, wr, wi);
    logic signed [PW-1:0] xr, xi, yr, yi;
    xr = ar; xi = ai; yr = wr; yi = wi;
    return xr * yi + xi * yr;
  endfunction

  // Round half-up toward +inf, then drop the fractional bits of the twiddle.
  function automatic logic signed [PW-1:0] round_q(input logic signed [PW-1:0] p);
    return (p + RND_C) >>> FRAC;
  endfunction

`ifdef FFT_TWID_SAT_EN
  function automatic logic is_clamp(input logic signed [PW-1:0] r);
    return (r > MAX_C) || (r < MIN_C);
  endfunction

  function automatic logic [WIDTH-1:0] narrow(input logic signed [PW-1:0] r);
    logic [WIDTH-1:0] n;
    if (r > MAX_C) begin
      n = MAX_C[WIDTH-1:0];
    end else if (r < MIN_C) begin
      n = MIN_C[WIDTH-1:0];
    end else begin
      n = r[WIDTH-1:0];
    end
    return n;
  endfunction
`else
  function automatic logic [WIDTH-1:0] narrow(input logic signed [PW-1:0] r);
    return r[WIDTH-1:0];
  endfunction
`endif

  assign s2_en_s    = !out_valid_r || out_ready;
  assign s1_en_s    = !s1_valid_r || s2_en_s;
  assign accept_s   = in_valid && s1_en_s;
  assign in_ready   = s1_en_s;
  assign tw_address = stage_r;

  assign out_valid  = out_valid_r;
  assign out_re     = out_re_r;
  assign out_im     = out_im_r;
  assign out_stage  = out_stage_r;

  // Stage counter: start restarts the frame and wins over the per-accept increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stage_r <= 3'd0;
    end else if (start) begin
      stage_r <= 3'd0;
    end else if (accept_s) begin
      stage_r <= (stage_r >= LAST_STAGE) ? 3'd0 : stage_r + 3'd1;
    end
  end

  // S1: capture operands, the twiddles the ROM returns for stage_r, and the pre-start stage tag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_r <= 1'b0;
      s1_re_r    <= '0;
      s1_im_r    <= '0;
      s1_tw_re_r <= '0;
      s1_tw_im_r <= '0;
      s1_stage_r <= 3'd0;
    end else if (s1_en_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_re_r    <= in_re;
        s1_im_r    <= in_im;
        s1_tw_re_r <= tw_re;
        s1_tw_im_r <= tw_im;
        s1_stage_r <= stage_r;
      end
    end
  end

  // Per-lane complex multiply, rounding and narrowing of the S1 contents.
  always_comb begin
    prod_re_s = '0;
    prod_im_s = '0;
    rnd_re_s  = '{default: '0};
    rnd_im_s  = '{default: '0};
`ifdef FFT_TWID_SAT_EN
    clamp_s   = 1'b0;
`endif
    for (int k = 0; k < LANES; k++) begin
      rnd_re_s[k] = round_q(cmul_re(s1_re_r[k*WIDTH +: WIDTH], s1_im_r[k*WIDTH +: WIDTH],
                                    s1_tw_re_r[k*WIDTH +: WIDTH], s1_tw_im_r[k*WIDTH +: WIDTH]));
      rnd_im_s[k] = round_q(cmul_im(s1_re_r[k*WIDTH +: WIDTH], s1_im_r[k*WIDTH +: WIDTH],
                                    s1_tw_re_r[k*WIDTH +: WIDTH], s1_tw_im_r[k*WIDTH +: WIDTH]));
      prod_re_s[k*WIDTH +: WIDTH] = narrow(rnd_re_s[k]);
      prod_im_s[k*WIDTH +: WIDTH] = narrow(rnd_im_s[k]);
`ifdef FFT_TWID_SAT_EN
      clamp_s = clamp_s | is_clamp(rnd_re_s[k]) | is_clamp(rnd_im_s[k]);
`endif
    end
  end

  // S2: output registers, frozen while the consumer stalls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_r <= 1'b0;
      out_re_r    <= '0;
      out_im_r    <= '0;
      out_stage_r <= 3'd0;
    end else if (s2_en_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_re_r    <= prod_re_s;
        out_im_r    <= prod_im_s;
        out_stage_r <= s1_stage_r;
      end
    end
  end

`ifdef FFT_TWID_SAT_EN
  // Sticky overflow: set when a clamped vector moves into S2, cleared only by reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_r <= 1'b0;
    end else if (s2_en_s && s1_valid_r && clamp_s) begin
      ovf_r <= 1'b1;
    end
  end
  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_twiddle_multiplier.sv
// Scoreboard bench for fft_twiddle_multiplier: directed vectors, backpressure, stage wrap/start and reset.
module tb_fft_twiddle_multiplier;
  localparam int W  = 16;
  localparam int F  = 8;
  localparam int L  = 16;
  localparam int VW = W * L;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    tw_address;
  logic [VW-1:0] tw_re = '0, tw_im = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_re = '0, in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [VW-1:0] out_re, out_im;
  logic [2:0]    out_stage;
  logic          ovf;

  fft_twiddle_multiplier #(.WIDTH(W), .FRAC(F)) dut (
    .CLK(CLK), .RST(RST), .start(start), .tw_address(tw_address),
    .tw_re(tw_re), .tw_im(tw_im), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_stage(out_stage), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [VW-1:0] re;
    logic [VW-1:0] im;
    logic [2:0]    stg;
    logic          clamp;
    logic          ovf;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [2:0] model_stage = 3'd0;
  logic       sticky_m = 1'b0;
  logic [VW-1:0] held_re;
  logic [2:0]    held_stg;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference narrowing: rounding by integer arithmetic, then clamp or wrap.
  function automatic logic [W:0] nref(input longint p);
    longint r;
    logic [63:0] u;
    r = (p + (longint'(1) <<< (F - 1))) >>> F;
`ifdef FFT_TWID_SAT_EN
    if (r > MAXV) return {1'b1, W'(MAXV)};
    if (r < MINV) return {1'b1, W'(MINV)};
`endif
    u = r;
    return {1'b0, u[W-1:0]};
  endfunction

  function automatic exp_t model(input logic [VW-1:0] are, aim, wre, wim, input logic [2:0] stg);
    exp_t e;
    logic [W:0] nr, ni;
    longint ar, ai, wr, wi;
    e.stg = stg; e.clamp = 1'b0; e.ovf = 1'b0; e.re = '0; e.im = '0;
    for (int k = 0; k < L; k++) begin
      ar = longint'($signed(are[k*W +: W]));
      ai = longint'($signed(aim[k*W +: W]));
      wr = longint'($signed(wre[k*W +: W]));
      wi = longint'($signed(wim[k*W +: W]));
      nr = nref(ar * wr - ai * wi);
      ni = nref(ar * wi + ai * wr);
      e.re[k*W +: W] = nr[W-1:0];
      e.im[k*W +: W] = ni[W-1:0];
      e.clamp = e.clamp | nr[W] | ni[W];
    end
    return e;
  endfunction

  function automatic logic [VW-1:0] mkvec(input logic [W-1:0] lane0, input bit rnd);
    logic [VW-1:0] v;
    for (int k = 0; k < L; k++)
      v[k*W +: W] = (k == 0 || !rnd) ? lane0 : 16'($urandom_range(2000)) - 16'd1000;
    return v;
  endfunction

  task automatic wait_accept(input bit st);
    exp_t e;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      check("tw_address", tw_address, model_stage);
      if (in_ready) begin
        e = model(in_re, in_im, tw_re, tw_im, model_stage);
        sticky_m = sticky_m | e.clamp;
        e.ovf = sticky_m;
        sb.push_back(e);
        model_stage = st ? 3'd0 : (model_stage == 3'd4 ? 3'd0 : model_stage + 3'd1);
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++; fails++;
      $error("FAIL accept_timeout observed=no accept expected=accept within 50 cycles");
    end
  endtask

  task automatic send(input logic [VW-1:0] re, input logic [VW-1:0] im, input bit st);
    @(posedge CLK); #1;
    in_valid = 1'b1; in_re = re; in_im = im; start = st;
    wait_accept(st);
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    if (sb.size() != 0) begin
      tests++; fails++;
      $error("FAIL drain_timeout observed=%0d pending expected=0 pending", sb.size());
    end
  endtask

  // Scoreboard: compare every transferred product vector with the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RST && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $error("FAIL sb_unexpected observed=out_valid expected=no output");
      end else begin
        e = sb.pop_front();
        check("out_re", out_re, e.re);
        check("out_im", out_im, e.im);
        check("out_stage", out_stage, e.stg);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  initial begin
    #1 RST = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_re", out_re, '0);
    check("rst_out_im", out_im, '0);
    check("rst_out_stage", out_stage, 3'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_tw_address", tw_address, 3'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Identity twiddle, latency and address advance.
    tw_re = {L{16'd256}}; tw_im = '0;
    send(mkvec(16'd100, 1'b1), mkvec(16'hFFCE, 1'b1), 1'b0);
    idle();
    @(negedge CLK);
    check("lat1_valid", out_valid, 1'b0);
    check("tw_addr_after", tw_address, 3'd1);
    @(negedge CLK);
    check("lat2_valid", out_valid, 1'b1);
    check("id_re_lane0", out_re[W-1:0], 16'd100);
    check("id_im_lane0", out_im[W-1:0], 16'hFFCE);
    check("id_stage", out_stage, 3'd0);

    // W8 twiddle (181, -181).
    tw_re = {L{16'd181}}; tw_im = {L{16'hFF4B}};
    send(mkvec(16'd256, 1'b1), mkvec(16'd0, 1'b1), 1'b0);
    send(mkvec(16'd0, 1'b1), mkvec(16'd256, 1'b1), 1'b0);
    idle();
    wait_empty();

    // Rounding half-up on both signs.
    tw_re = {L{16'd128}}; tw_im = '0;
    send(mkvec(16'd3, 1'b1), mkvec(16'd0, 1'b1), 1'b0);
    send(mkvec(16'hFFFD, 1'b1), mkvec(16'd0, 1'b1), 1'b0);
    idle();
    wait_empty();

    // Backpressure: two accepted, third stalls while output holds.
    tw_re = {L{16'd256}}; tw_im = {L{16'd64}};
    out_ready = 1'b0;
    send(mkvec(16'd11, 1'b1), mkvec(16'd12, 1'b1), 1'b0);
    send(mkvec(16'd21, 1'b1), mkvec(16'd22, 1'b1), 1'b0);
    @(posedge CLK); #1;
    in_re = mkvec(16'd31, 1'b1); in_im = mkvec(16'd32, 1'b1);
    held_re = out_re; held_stg = out_stage;
    repeat (3) begin
      @(negedge CLK);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_hold_re", out_re, held_re);
      check("bp_hold_stage", out_stage, held_stg);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    wait_accept(1'b0);
    idle();
    wait_empty();

    // Overflow: imag product exceeds the lane range.
    tw_re = {L{16'd256}}; tw_im = {L{16'd256}};
    send({L{16'h7FFF}}, {L{16'h7FFF}}, 1'b0);
    idle();
    wait_empty();
`ifdef FFT_TWID_SAT_EN
    check("ovf_sticky", ovf, 1'b1);
`else
    check("ovf_sticky", ovf, 1'b0);
`endif

    // Stage wrap after a frame restart, then start coinciding with accept at stage 2.
    tw_re = {L{16'd256}}; tw_im = '0;
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    model_stage = 3'd0;
    for (int i = 0; i < 7; i++) send(mkvec(16'(i * 7), 1'b1), mkvec(16'(i * 3), 1'b1), 1'b0);
    send(mkvec(16'd77, 1'b1), mkvec(16'd88, 1'b1), 1'b1);
    send(mkvec(16'd5, 1'b1), mkvec(16'd6, 1'b1), 1'b0);
    idle();
    wait_empty();

    // Asynchronous reset with vectors in flight.
    send(mkvec(16'd40, 1'b1), mkvec(16'd41, 1'b1), 1'b0);
    send(mkvec(16'd50, 1'b1), mkvec(16'd51, 1'b1), 1'b0);
    idle();
    check("pre_rst_valid", out_valid, 1'b1);
    RST = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_tw_address", tw_address, 3'd0);
    sb.delete();
    model_stage = 3'd0;
    sticky_m = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    send(mkvec(16'd123, 1'b1), mkvec(16'd321, 1'b1), 1'b0);
    idle();
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
